sw_cmd_conditioner: RTL and testbench

- Conditions the three raw slide-switch inputs before the PWM duty controller.
- SW[0] is power enable, SW[1] is increase and SW[2] is decrease.
- Synchronises and debounces each switch, then converts increase/decrease presses into single-cycle command pulses, with auto-repeat while a switch is held.
- Sits between the board switches and the duty-cycle register / HEX display path inside top.

---
 rtl/sw_cmd_pkg.sv | 29 ++
 rtl/sw_debounce.sv | 41 ++++
 rtl/sw_cmd_conditioner.sv | 121 ++++++++++++
 tb/tb_sw_cmd_conditioner.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/sw_cmd_pkg.sv
// Shared types and timing constants for the slide-switch command conditioner.
// Simulation-scale values keep benches short without touching the RTL.
package sw_cmd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        REPEAT,
        LOCKED
    } state_t;

    typedef enum logic {
        DIR_INC,
        DIR_DEC
    } dir_t;

    localparam int DEF_DEBOUNCE_CYCLES = 500000;
    localparam int DEF_REPEAT_DELAY    = 25000000;
    localparam int DEF_REPEAT_PERIOD   = 5000000;

    localparam int SIM_DEBOUNCE_CYCLES = 4;
    localparam int SIM_REPEAT_DELAY    = 20;
    localparam int SIM_REPEAT_PERIOD   = 8;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sw_debounce.sv
// Two-flop synchroniser followed by a mismatch-run debounce counter.
// The stable level flips only after DEBOUNCE_CYCLES consecutive mismatches.
module sw_debounce
    import sw_cmd_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic stable
);

    localparam int CW = cnt_w(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_END = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            cnt    <= '0;
            stable <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            if (s2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_END) begin
                stable <= s2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sw_cmd_conditioner.sv
// Debounced switch levels plus inc/dec command pulses with auto-repeat.
// Commands are armed only when enable was already high before the key rose.
module sw_cmd_conditioner
    import sw_cmd_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] SW,
    output logic [2:0] sw_stable,
    output logic       en,
    output logic       inc_pulse,
    output logic       dec_pulse
);

    localparam int TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                          REPEAT_DELAY : REPEAT_PERIOD;
    localparam int TW = cnt_w(TMAX);
    localparam logic [TW-1:0] DLY_END = TW'(REPEAT_DELAY - 1);
    localparam logic [TW-1:0] PER_END = TW'(REPEAT_PERIOD - 1);

    for (genvar i = 0; i < 3; i++) begin : g_db
        sw_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk   (clk),
            .rst_n (rst_n),
            .raw   (SW[i]),
            .stable(sw_stable[i])
        );
    end

    logic [2:0]    stable_q;
    logic [2:0]    rise;
    state_t        state, state_d;
    dir_t          dir, dir_d;
    logic [TW-1:0] timer, timer_d;
    logic [TW-1:0] t_end;
    logic          inc_d, dec_d;
    logic          held, other, any_key, armed;

    assign rise    = sw_stable & ~stable_q;
    assign held    = (dir == DIR_INC) ? sw_stable[1] : sw_stable[2];
    assign other   = (dir == DIR_INC) ? sw_stable[2] : sw_stable[1];
    assign any_key = sw_stable[1] | sw_stable[2];
    // A key and enable rising together (e.g. after reset) must not fire
    assign armed   = sw_stable[0] & stable_q[0];
    assign t_end   = (state == DELAY) ? DLY_END : PER_END;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_q  <= '0;
            state     <= IDLE;
            dir       <= DIR_INC;
            timer     <= '0;
            inc_pulse <= 1'b0;
            dec_pulse <= 1'b0;
        end else begin
            stable_q  <= sw_stable;
            state     <= state_d;
            dir       <= dir_d;
            timer     <= timer_d;
            inc_pulse <= inc_d;
            dec_pulse <= dec_d;
        end
    end

    always_comb begin
        state_d = state;
        dir_d   = dir;
        timer_d = timer;
        inc_d   = 1'b0;
        dec_d   = 1'b0;
        unique case (state)
            IDLE: begin
                if (armed) begin
                    if (rise[1] && rise[2]) begin
                        state_d = LOCKED;
                    end else if (rise[1]) begin
                        inc_d   = 1'b1;
                        dir_d   = DIR_INC;
                        timer_d = '0;
                        state_d = DELAY;
                    end else if (rise[2]) begin
                        dec_d   = 1'b1;
                        dir_d   = DIR_DEC;
                        timer_d = '0;
                        state_d = DELAY;
                    end
                end
            end
            DELAY, REPEAT: begin
                if (!sw_stable[0]) begin
                    state_d = any_key ? LOCKED : IDLE;
                end else if (!held) begin
                    state_d = IDLE;
                end else if (other) begin
                    state_d = LOCKED;
                end else if (timer == t_end) begin
                    inc_d   = (dir == DIR_INC);
                    dec_d   = (dir == DIR_DEC);
                    timer_d = '0;
                    state_d = REPEAT;
                end else begin
                    timer_d = timer + 1'b1;
                end
            end
            LOCKED: begin
                if (!any_key) state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        en = sw_stable[0];
    end

endmodule

// File: tb/tb_sw_cmd_conditioner.sv
// Scoreboard bench: expected pulse cycles are queued with the stimulus
// and matched against observed pulses on the falling clock edge.
module tb_sw_cmd_conditioner;
    import sw_cmd_pkg::*;

    typedef struct {
        logic dec;
        int   cyc;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] SW = 3'b001;
    logic [2:0] sw_stable;
    logic       en;
    logic       inc_pulse;
    logic       dec_pulse;

    int  cyc = 0;
    int  n_cmp = 0;
    int  n_err = 0;
    ev_t sb[$];
    ev_t ev;

    sw_cmd_conditioner #(
        .DEBOUNCE_CYCLES(SIM_DEBOUNCE_CYCLES),
        .REPEAT_DELAY   (SIM_REPEAT_DELAY),
        .REPEAT_PERIOD  (SIM_REPEAT_PERIOD)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .SW       (SW),
        .sw_stable(sw_stable),
        .en       (en),
        .inc_pulse(inc_pulse),
        .dec_pulse(dec_pulse)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    task automatic set_sw(input logic [2:0] v, output int e);
        @(posedge clk);
        #1;
        SW = v;
        e  = cyc + 1;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic dec, input int c);
        ev_t x;
        x.dec = dec;
        x.cyc = c;
        sb.push_back(x);
    endtask

    task automatic drain(input string tag);
        chk(tag, sb.size(), 0);
        sb.delete();
    endtask

    always @(negedge clk) begin
        if (inc_pulse || dec_pulse) begin
            chk("excl", 32'(inc_pulse & dec_pulse), 0);
            if (sb.size() == 0) begin
                chk("spurious", cyc, -1);
            end else begin
                ev = sb.pop_front();
                chk("pdir", 32'(dec_pulse), 32'(ev.dec));
                chk("pcyc", cyc, ev.cyc);
            end
        end
    end

    initial begin
        int  e;
        logic acc;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_stable", 32'(sw_stable), 0);
        chk("rst_en", 32'(en), 0);
        chk("rst_pulse", 32'({inc_pulse, dec_pulse}), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        wait_cyc(12);
        chk("en_up", 32'(en), 1);
        chk("stable_en", 32'(sw_stable), 1);

        // 1: glitch of 3 cycles
        set_sw(3'b011, e);
        repeat (3) @(posedge clk);
        #1 SW = 3'b001;
        acc = 1'b0;
        repeat (12) begin
            @(negedge clk);
            acc = acc | sw_stable[1];
        end
        chk("glitch", 32'(acc), 0);
        drain("drain_glitch");

        // 2: single press, 15 cycles
        set_sw(3'b011, e);
        push(1'b0, e + 6);
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("s1_pre", 32'(sw_stable[1]), 0);
        @(posedge clk);
        @(negedge clk);
        chk("s1_rise", 32'(sw_stable[1]), 1);
        repeat (8) @(posedge clk);
        set_sw(3'b001, e);
        wait_cyc(30);
        chk("s1_fall", 32'(sw_stable[1]), 0);
        drain("drain_single");

        // 3: hold and auto-repeat
        set_sw(3'b011, e);
        push(1'b0, e + 6);
        for (int k = 0; k < 5; k++) push(1'b0, e + 26 + 8 * k);
        repeat (59) @(posedge clk);
        set_sw(3'b001, e);
        wait_cyc(30);
        drain("drain_repeat");

        // 4: conflicting keys
        set_sw(3'b111, e);
        wait_cyc(20);
        chk("both_stable", 32'(sw_stable), 7);
        set_sw(3'b101, e);
        wait_cyc(20);
        set_sw(3'b001, e);
        wait_cyc(20);
        set_sw(3'b101, e);
        push(1'b1, e + 6);
        wait_cyc(15);
        set_sw(3'b001, e);
        wait_cyc(20);
        drain("drain_conflict");

        // 5: enable gating
        set_sw(3'b000, e);
        wait_cyc(20);
        chk("en_low", 32'(en), 0);
        set_sw(3'b010, e);
        wait_cyc(20);
        set_sw(3'b011, e);
        wait_cyc(30);
        chk("en_back", 32'(en), 1);
        set_sw(3'b001, e);
        wait_cyc(20);
        set_sw(3'b011, e);
        push(1'b0, e + 6);
        wait_cyc(15);
        set_sw(3'b001, e);
        wait_cyc(20);
        drain("drain_enable");

        // 6: reset during repeat
        set_sw(3'b011, e);
        push(1'b0, e + 6);
        push(1'b0, e + 26);
        repeat (30) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_stable", 32'(sw_stable), 0);
        chk("mid_rst_en", 32'(en), 0);
        chk("mid_rst_pulse", 32'({inc_pulse, dec_pulse}), 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        wait_cyc(40);
        chk("post_rst_stable", 32'(sw_stable), 3);
        set_sw(3'b001, e);
        wait_cyc(20);
        set_sw(3'b011, e);
        push(1'b0, e + 6);
        wait_cyc(15);
        set_sw(3'b001, e);
        wait_cyc(20);
        drain("drain_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
